// File: rtl/uart_host_pkg.sv
// Shared definitions for the host-poll UART responder: FSM states,
// command and header field layout, and small decode helpers.
package uart_host_pkg;

    // Upper bound on channels; a 5-bit channel field addresses at most 32.
    localparam int MAX_CH = 32;

    // Command byte layout: {opcode[2:0], channel[4:0]}
    localparam logic [2:0] POLL_OPCODE = 3'b101;
    localparam int CMD_OP_MSB = 7;
    localparam int CMD_OP_LSB = 5;
    localparam int CMD_CH_MSB = 4;
    localparam int CMD_CH_LSB = 0;

    // Header byte layout: {fresh, 2'b00, channel[4:0]}
    localparam int HDR_FRESH_BIT = 7;
    localparam int HDR_CH_MSB    = 4;
    localparam int HDR_CH_LSB    = 0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SNAP,
        PAYLOAD,
        CSUM,
        LAST
    } host_state_t;

    // Build the frame header from the fresh flag and channel number.
    function automatic logic [7:0] make_hdr(input logic fresh, input logic [4:0] ch);
        logic [7:0] hdr;
        hdr = '0;
        hdr[HDR_FRESH_BIT] = fresh;
        hdr[HDR_CH_MSB:HDR_CH_LSB] = ch;
        return hdr;
    endfunction

    // A command is accepted only as a poll of an existing channel.
    function automatic logic is_valid_poll(input logic [7:0] cmd, input int num_ch);
        logic [4:0] ch;
        ch = cmd[CMD_CH_MSB:CMD_CH_LSB];
        return (cmd[CMD_OP_MSB:CMD_OP_LSB] == POLL_OPCODE) &&
               (int'({27'd0, ch}) < num_ch);
    endfunction

endpackage

// File: rtl/uart_pkt_serializer.sv
// Frame serializer: holds the frozen payload snapshot, walks the byte
// index, accumulates the XOR checksum and drives the UART_tx handshake.
// The controlling FSM decides when each byte goes out; this block decides
// which byte it is and keeps tx_data stable between start pulses.
module uart_pkt_serializer #(
    parameter int PKT_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [PKT_BYTES*8-1:0] i_load_data,
    input  logic [7:0]             i_hdr,
    input  logic                   i_send_byte,
    input  logic                   i_send_csum,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_trmt,
    output logic                   o_last_byte
);

    localparam int IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

    logic [7:0]       r_snap [PKT_BYTES];
    logic [7:0]       w_load_bytes [PKT_BYTES];
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_csum;
    logic [7:0]       r_tx_data;
    logic [7:0]       w_cur_byte;
    logic [7:0]       w_byte;
    logic             w_trmt;

    // Split the incoming packet into bytes, little-endian (byte 0 = [7:0]).
    for (genvar gi = 0; gi < PKT_BYTES; gi++) begin : g_split
        assign w_load_bytes[gi] = i_load_data[gi*8 +: 8];
    end

    // Select the snapshot byte addressed by the current index.
    always_comb begin
        w_cur_byte = '0;
        for (int b = 0; b < PKT_BYTES; b++) begin
            if (r_idx == IDX_W'(b)) begin
                w_cur_byte = r_snap[b];
            end
        end
    end

    // Pick the byte being launched: header, payload byte, or checksum.
    always_comb begin
        w_trmt = i_load | i_send_byte | i_send_csum;
        if (i_load) begin
            w_byte = i_hdr;
        end else if (i_send_byte) begin
            w_byte = w_cur_byte;
        end else begin
            w_byte = r_csum;
        end
    end

    // Snapshot, index and checksum update; remember the launched byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_csum    <= '0;
            r_tx_data <= '0;
            for (int b = 0; b < PKT_BYTES; b++) begin
                r_snap[b] <= '0;
            end
        end else begin
            if (i_load) begin
                for (int b = 0; b < PKT_BYTES; b++) begin
                    r_snap[b] <= w_load_bytes[b];
                end
                r_idx  <= '0;
                r_csum <= i_hdr;
            end else if (i_send_byte) begin
                r_idx  <= r_idx + 1'b1;
                r_csum <= r_csum ^ w_cur_byte;
            end
            if (w_trmt) begin
                r_tx_data <= w_byte;
            end
        end
    end

    // The start pulse is combinational with its trigger so a payload byte
    // can launch in the same cycle as the previous tx_done.
    assign o_tx_trmt   = w_trmt;
    assign o_tx_data   = w_trmt ? w_byte : r_tx_data;
    assign o_last_byte = (r_idx == IDX_W'(PKT_BYTES - 1));

endmodule

// File: rtl/uart_host_mux.sv
// Multi-channel UART host responder: buffers controller packets per
// channel, decodes host poll commands and replies with a framed packet
// (header, payload, optional XOR checksum) over the UART_tx handshake.
module uart_host_mux #(
    parameter int NUM_CH     = 4,
    parameter int PKT_BYTES  = 4,
    parameter int WAIT_FRESH = 1,
    parameter int CSUM_EN    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH*PKT_BYTES*8-1:0] pkt_data,
    input  logic [NUM_CH-1:0]             pkt_vld,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_rdy,
    output logic                          rx_clr_rdy,
    output logic [7:0]                    tx_data,
    output logic                          tx_trmt,
    input  logic                          tx_done,
    output logic                          busy,
    output logic [7:0]                    bad_cmd_cnt
);

    import uart_host_pkg::*;

    localparam int PKT_W = PKT_BYTES * 8;

    logic [PKT_W-1:0] r_buf [NUM_CH];
    logic             r_fresh [NUM_CH];
    host_state_t      r_state;
    host_state_t      w_state_next;
    logic [4:0]       r_ch;
    logic [7:0]       r_bad_cnt;

    logic [PKT_W-1:0] w_sel_buf;
    logic [PKT_W-1:0] w_sel_pkt;
    logic             w_sel_vld;
    logic             w_sel_fresh;
    logic             w_cmd_fresh;
    logic             w_cmd_ok;
    logic [7:0]       w_hdr;
    logic [PKT_W-1:0] w_snap_data;

    logic             w_rx_clr;
    logic             w_latch;
    logic             w_bad;
    logic             w_snap;
    logic             w_send_byte;
    logic             w_send_csum;
    logic             w_last_byte;

    // Per-channel packet buffer and fresh flag. Strobes are taken in any
    // state; a snapshot of this channel clears fresh even if a strobe
    // lands in the same cycle (the snapshot consumes that data).
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        always_ff @(posedge clk) begin
            if (rst) begin
                r_buf[gi]   <= '0;
                r_fresh[gi] <= 1'b0;
            end else begin
                if (pkt_vld[gi]) begin
                    r_buf[gi] <= pkt_data[gi*PKT_W +: PKT_W];
                end
                if (w_snap && (r_ch == 5'(gi))) begin
                    r_fresh[gi] <= 1'b0;
                end else if (pkt_vld[gi]) begin
                    r_fresh[gi] <= 1'b1;
                end
            end
        end
    end

    // Channel selection for the latched channel and the incoming command.
    always_comb begin
        w_sel_buf   = '0;
        w_sel_pkt   = '0;
        w_sel_vld   = 1'b0;
        w_sel_fresh = 1'b0;
        w_cmd_fresh = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == 5'(c)) begin
                w_sel_buf   = r_buf[c];
                w_sel_pkt   = pkt_data[c*PKT_W +: PKT_W];
                w_sel_vld   = pkt_vld[c];
                w_sel_fresh = r_fresh[c];
            end
            if (rx_data[CMD_CH_MSB:CMD_CH_LSB] == 5'(c)) begin
                w_cmd_fresh = r_fresh[c];
            end
        end
    end

    assign w_cmd_ok    = is_valid_poll(rx_data, NUM_CH);
    assign w_hdr       = make_hdr(w_sel_fresh, r_ch);
    // A strobe arriving in the snapshot cycle wins over the stored buffer.
    assign w_snap_data = w_sel_vld ? w_sel_pkt : w_sel_buf;

    // Next-state and handshake decode for the poll/reply sequence.
    always_comb begin
        w_state_next = r_state;
        w_rx_clr     = 1'b0;
        w_latch      = 1'b0;
        w_bad        = 1'b0;
        w_snap       = 1'b0;
        w_send_byte  = 1'b0;
        w_send_csum  = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_rdy) begin
                    w_rx_clr = 1'b1;
                    w_latch  = 1'b1;
                    if (!w_cmd_ok) begin
                        w_bad = 1'b1;
                    end else if ((WAIT_FRESH != 0) && !w_cmd_fresh) begin
                        w_state_next = WAIT;
                    end else begin
                        w_state_next = SNAP;
                    end
                end
            end
            WAIT: begin
                if (w_sel_fresh) begin
                    w_state_next = SNAP;
                end
            end
            SNAP: begin
                w_snap       = 1'b1;
                w_state_next = PAYLOAD;
            end
            PAYLOAD: begin
                if (tx_done) begin
                    w_send_byte = 1'b1;
                    if (w_last_byte) begin
                        w_state_next = (CSUM_EN != 0) ? CSUM : LAST;
                    end
                end
            end
            CSUM: begin
                if (tx_done) begin
                    w_send_csum  = 1'b1;
                    w_state_next = LAST;
                end
            end
            LAST: begin
                if (tx_done) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register, latched channel and saturating reject counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ch      <= '0;
            r_bad_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_ch <= rx_data[CMD_CH_MSB:CMD_CH_LSB];
            end
            if (w_bad && (r_bad_cnt != 8'hFF)) begin
                r_bad_cnt <= r_bad_cnt + 8'd1;
            end
        end
    end

    uart_pkt_serializer #(
        .PKT_BYTES (PKT_BYTES)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_snap),
        .i_load_data (w_snap_data),
        .i_hdr       (w_hdr),
        .i_send_byte (w_send_byte),
        .i_send_csum (w_send_csum),
        .o_tx_data   (tx_data),
        .o_tx_trmt   (tx_trmt),
        .o_last_byte (w_last_byte)
    );

    assign rx_clr_rdy  = w_rx_clr;
    assign busy        = (r_state != IDLE);
    assign bad_cmd_cnt = r_bad_cnt;

endmodule

// File: tb/tb_uart_host_mux.sv
// Self-checking bench: two responders (instance 0 waits for fresh data,
// instance 1 replies immediately) driven by randomized controller strobes
// and host commands. Expected frames come from a per-channel model and are
// queued; a monitor per instance pops and compares every launched byte.
module tb_uart_host_mux;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [1:0][127:0]     pkt_data = '0;
    logic [1:0][3:0]       pkt_vld = '0;
    logic [1:0][7:0]       rx_data = '0;
    logic [1:0]            rx_rdy = '0;
    wire  [1:0]            rx_clr;
    wire  [1:0][7:0]       tx_data;
    wire  [1:0]            tx_trmt;
    wire  [1:0]            busy;
    wire  [1:0][7:0]       bad_cnt;

    int checks = 0;
    int errors = 0;

    logic [8:0]  exp_q [$];
    logic [31:0] m_buf   [2][4];
    bit          m_fresh [2][4];
    int          m_bad   [2];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic       done_r = 1'b0;
        int         cnt = 0;
        bit         inflight = 1'b0;
        logic [7:0] last_data = '0;
        logic [8:0] e;

        uart_host_mux #(
            .NUM_CH     (4),
            .PKT_BYTES  (4),
            .WAIT_FRESH ((gi == 0) ? 1 : 0),
            .CSUM_EN    (1)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .pkt_data    (pkt_data[gi]),
            .pkt_vld     (pkt_vld[gi]),
            .rx_data     (rx_data[gi]),
            .rx_rdy      (rx_rdy[gi]),
            .rx_clr_rdy  (rx_clr[gi]),
            .tx_data     (tx_data[gi]),
            .tx_trmt     (tx_trmt[gi]),
            .tx_done     (done_r),
            .busy        (busy[gi]),
            .bad_cmd_cnt (bad_cnt[gi])
        );

        // Monitor: compare each launched byte with the scoreboard.
        always @(negedge clk) begin
            if (rst) begin
                inflight = 1'b0;
                cnt = 0;
            end else begin
                if (done_r) inflight = 1'b0;
                if (tx_trmt[gi]) begin
                    if (inflight) check("trmt_without_done", 1, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_tx", {24'd0, tx_data[gi]}, 32'h100);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", {23'd0, 1'(gi), tx_data[gi]}, {23'd0, e});
                    end
                    inflight  = 1'b1;
                    cnt       = $urandom_range(1, 4);
                    last_data = tx_data[gi];
                end else if (inflight) begin
                    check("tx_data_hold", {24'd0, tx_data[gi]}, {24'd0, last_data});
                end
            end
        end

        // UART_tx model: finish each byte after a random delay.
        always @(posedge clk) begin
            #1;
            done_r = 1'b0;
            if (inflight && cnt > 0) begin
                cnt--;
                if (cnt == 0) done_r = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int inst, input int ch, input logic [31:0] d);
        pkt_data[inst][ch*32 +: 32] = d;
        pkt_vld[inst][ch] = 1'b1;
        m_buf[inst][ch] = d;
        m_fresh[inst][ch] = 1'b1;
        tick();
        pkt_vld[inst] = '0;
    endtask

    // Queue the frame the model says channel ch must produce next.
    task automatic expect_frame(input int inst, input int ch);
        logic [7:0] b;
        logic [7:0] cs;
        logic [31:0] w;
        b = {m_fresh[inst][ch], 2'b00, 5'(ch)};
        exp_q.push_back({1'(inst), b});
        cs = b;
        w = m_buf[inst][ch];
        for (int k = 0; k < 4; k++) begin
            b = w[k*8 +: 8];
            exp_q.push_back({1'(inst), b});
            cs = cs ^ b;
        end
        exp_q.push_back({1'(inst), cs});
        m_fresh[inst][ch] = 1'b0;
    endtask

    task automatic send_cmd(input int inst, input logic [7:0] cmd);
        bit seen;
        seen = 1'b0;
        $display("cmd inst=%0d byte=%02h", inst, cmd);
        rx_data[inst] = cmd;
        rx_rdy[inst] = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rx_clr[inst]) seen = 1'b1;
        end
        tick();
        rx_rdy[inst] = 1'b0;
        check("rx_clr_pulse", {31'd0, seen}, 1);
        if (cmd[7:5] != 3'b101 || cmd[4:0] >= 5'd4) begin
            if (m_bad[inst] < 255) m_bad[inst]++;
        end
        check("bad_cnt", {24'd0, bad_cnt[inst]}, m_bad[inst]);
    endtask

    task automatic wait_q(input int n);
        for (int i = 0; i < 200 && exp_q.size() > n; i++) @(negedge clk);
        check("queue_level", (exp_q.size() > n) ? 1 : 0, 0);
        tick();
    endtask

    task automatic wait_idle(input int inst);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || busy[inst]); i++) @(negedge clk);
        check("q_empty", exp_q.size(), 0);
        check("busy_end", {31'd0, busy[inst]}, 0);
        tick();
    endtask

    task automatic bad_cmd_byte(output logic [7:0] c);
        c = 8'($urandom_range(0, 255));
        if (c[7:5] == 3'b101 && c[4:0] < 5'd4) c = c ^ 8'h80;
    endtask

    initial begin
        logic [7:0] c;
        int inst;
        int ch;
        for (int i = 0; i < 2; i++) begin
            m_bad[i] = 0;
            for (int j = 0; j < 4; j++) begin
                m_buf[i][j] = '0;
                m_fresh[i][j] = 1'b0;
            end
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_rx_clr", {31'd0, rx_clr[i]}, 0);
            check("rst_trmt", {31'd0, tx_trmt[i]}, 0);
            check("rst_tx_data", {24'd0, tx_data[i]}, 0);
            check("rst_busy", {31'd0, busy[i]}, 0);
            check("rst_bad", {24'd0, bad_cnt[i]}, 0);
        end
        tick();
        rst = 1'b0;
        tick();

        // 1: fresh poll of channel 2
        strobe(0, 2, 32'h44332211);
        expect_frame(0, 2);
        send_cmd(0, 8'hA2);
        wait_idle(0);

        // 2: poll blocks until data arrives
        send_cmd(0, 8'hA1);
        repeat (200) tick();
        check("wait_busy", {31'd0, busy[0]}, 1);
        strobe(0, 1, 32'hDEADBEEF);
        expect_frame(0, 1);
        wait_idle(0);

        // 3: immediate replies, second one stale
        strobe(1, 0, 32'h04030201);
        expect_frame(1, 0);
        send_cmd(1, 8'hA0);
        wait_idle(1);
        expect_frame(1, 0);
        send_cmd(1, 8'hA0);
        wait_idle(1);

        // 4: rejected commands and saturation
        send_cmd(0, 8'h37);
        send_cmd(0, 8'hA5);
        check("bad_two", {24'd0, bad_cnt[0]}, 2);
        for (int i = 0; i < 300; i++) begin
            bad_cmd_byte(c);
            send_cmd(0, c);
        end
        check("bad_sat", {24'd0, bad_cnt[0]}, 255);

        // Randomized mix on both instances
        for (int it = 0; it < 40; it++) begin
            inst = $urandom_range(0, 1);
            for (int s = $urandom_range(0, 3); s > 0; s--) begin
                strobe(inst, $urandom_range(0, 3), $urandom);
            end
            if ($urandom_range(0, 4) == 0) begin
                bad_cmd_byte(c);
                send_cmd(inst, c);
            end else begin
                ch = $urandom_range(0, 3);
                if (inst == 0 && !m_fresh[0][ch]) begin
                    send_cmd(0, 8'hA0 | 8'(ch));
                    repeat ($urandom_range(1, 10)) tick();
                    check("wait_busy_rand", {31'd0, busy[0]}, 1);
                    strobe(0, ch, $urandom);
                    expect_frame(0, ch);
                end else begin
                    expect_frame(inst, ch);
                    send_cmd(inst, 8'hA0 | 8'(ch));
                end
            end
            wait_idle(inst);
        end

        // 5: strobe in the snapshot cycle, then a strobe mid-frame
        strobe(0, 2, 32'h55667788);
        rx_data[0] = 8'hA2;
        rx_rdy[0] = 1'b1;
        $display("cmd inst=0 byte=a2 (snapshot collision)");
        @(negedge clk);
        check("rx_clr_collision", {31'd0, rx_clr[0]}, 1);
        tick();
        rx_rdy[0] = 1'b0;
        m_buf[0][2] = 32'h0A0B0C0D;
        expect_frame(0, 2);
        pkt_data[0][2*32 +: 32] = 32'h0A0B0C0D;
        pkt_vld[0][2] = 1'b1;
        tick();
        pkt_vld[0] = '0;
        wait_q(3);
        strobe(0, 2, 32'h11111111);
        wait_idle(0);
        expect_frame(0, 2);
        send_cmd(0, 8'hA2);
        wait_idle(0);

        // 6: reset during payload byte 2
        strobe(0, 3, $urandom);
        expect_frame(0, 3);
        send_cmd(0, 8'hA3);
        wait_q(2);
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            m_bad[i] = 0;
            for (int j = 0; j < 4; j++) begin
                m_buf[i][j] = '0;
                m_fresh[i][j] = 1'b0;
            end
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_trmt", {31'd0, tx_trmt[0]}, 0);
        check("mid_rst_busy", {31'd0, busy[0]}, 0);
        check("mid_rst_bad", {24'd0, bad_cnt[0]}, 0);
        tick();
        send_cmd(0, 8'hA2);
        repeat (50) tick();
        check("post_rst_wait", {31'd0, busy[0]}, 1);
        strobe(0, 2, 32'hCAFEF00D);
        expect_frame(0, 2);
        wait_idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
